// File: rtl/image_ctrl_pkg.sv
// Shared definitions for the image frame sequencer: FSM state encoding,
// default frame timing and the widths of the row/column/delay counters.
package image_ctrl_pkg;

  localparam int unsigned DEF_WIDTH          = 1680;
  localparam int unsigned DEF_HEIGHT         = 1050;
  localparam int unsigned DEF_START_UP_DELAY = 100;
  localparam int unsigned DEF_HSYNC_DELAY    = 160;

  localparam int unsigned ROW_W = 11;
  localparam int unsigned COL_W = 11;
  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_HSYNC,
    S_DATA,
    S_DONE
  } state_t;

  // Terminal count of the delay timer for a phase lasting 'cycles' cycles.
  function automatic logic [TMR_W-1:0] delay_last(input int unsigned cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/image_frame_sequencer_sync_timer.sv
// sync_timer: 16-bit up-counter used for the VSYNC and inter-line blank
// phases. 'load' restarts from zero, 'count' advances, and 'expired' flags
// the cycle in which the count equals the programmed terminal value.
module sync_timer
  import image_ctrl_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             load,
  input  logic             count,
  input  logic [TMR_W-1:0] last,
  output logic             expired
);

  logic [TMR_W-1:0] count_q;

  // Counter register: load has priority over counting.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (count) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

  assign expired = count && (count_q == last);

endmodule

// File: rtl/image_frame_sequencer.sv
// image_frame_sequencer: walks a WIDTH x HEIGHT image two pixels per beat,
// framing it with a VSYNC start-up phase and an inter-line blank before
// every line. pix_addr is kept as a running register (advanced by 2 on each
// beat) so it always equals row*WIDTH+col without a multiplier.
// Optional feature: define AUTO_RESTART_EN for back-to-back frames until abort.
module image_frame_sequencer
  import image_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH          = DEF_WIDTH,
  parameter  int unsigned HEIGHT         = DEF_HEIGHT,
  parameter  int unsigned START_UP_DELAY = DEF_START_UP_DELAY,
  parameter  int unsigned HSYNC_DELAY    = DEF_HSYNC_DELAY,
  localparam int unsigned ADDR_W         = $clog2(WIDTH * HEIGHT)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              busy,
  output logic              ctrl_done
);

  localparam logic [TMR_W-1:0] VS_LAST  = delay_last(START_UP_DELAY);
  localparam logic [TMR_W-1:0] HS_LAST  = delay_last(HSYNC_DELAY);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               tmr_load;
  logic               tmr_count;
  logic [TMR_W-1:0]   tmr_last;
  logic               tmr_expired;

  assign tmr_count = (state_q == S_VSYNC) || (state_q == S_HSYNC);
  assign tmr_last  = (state_q == S_VSYNC) ? VS_LAST : HS_LAST;

  sync_timer u_sync_timer (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (tmr_load),
    .count   (tmr_count),
    .last    (tmr_last),
    .expired (tmr_expired)
  );

  // State, position and address registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, position update and timer restart; abort overrides all.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    tmr_load = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_VSYNC;
          tmr_load = 1'b1;
        end
      end

      S_VSYNC: begin
        if (tmr_expired) begin
          state_d  = S_HSYNC;
          tmr_load = 1'b1;
        end
      end

      S_HSYNC: begin
        if (tmr_expired) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (out_ready) begin
          addr_d = addr_q + ADDR_W'(2);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d    = row_q + ROW_W'(1);
              state_d  = S_HSYNC;
              tmr_load = 1'b1;
            end
          end else begin
            col_d = col_q + COL_W'(2);
          end
        end
      end

      S_DONE: begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
`ifdef AUTO_RESTART_EN
        state_d  = S_VSYNC;
        tmr_load = 1'b1;
`else
        state_d  = S_IDLE;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      row_d    = '0;
      col_d    = '0;
      addr_d   = '0;
      tmr_load = 1'b1;
    end
  end

  assign out_valid = (state_q == S_DATA);
  assign HSYNC     = (state_q == S_DATA);
  assign VSYNC     = (state_q == S_VSYNC);
  assign busy      = (state_q != S_IDLE);
  // An abort arriving in DONE cancels the completion pulse.
  assign ctrl_done = (state_q == S_DONE) && !abort;
  assign pix_addr  = addr_q;
  assign row       = row_q;
  assign col       = col_q;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Testbench for image_frame_sequencer (WIDTH=4, HEIGHT=2, START_UP_DELAY=3,
// HSYNC_DELAY=2). The reference model expands each frame into a queue of
// expected phases (sync runs, blanks, one entry per pixel pair, done) and
// consumes it cycle by cycle according to the driven inputs.
module tb_image_frame_sequencer;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 2;
  localparam int unsigned SUD = 3;
  localparam int unsigned HSD = 2;

  localparam int K_VS   = 0;
  localparam int K_BLK  = 1;
  localparam int K_DATA = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int n;
  } seg_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [2:0]  pix_addr;
  logic [10:0] row;
  logic [10:0] col;
  logic        VSYNC;
  logic        HSYNC;
  logic        busy;
  logic        ctrl_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_seen = 0;
  seg_t        q[$];

  image_frame_sequencer #(
    .WIDTH          (W),
    .HEIGHT         (H),
    .START_UP_DELAY (SUD),
    .HSYNC_DELAY    (HSD)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .pix_addr  (pix_addr),
    .row       (row),
    .col       (col),
    .VSYNC     (VSYNC),
    .HSYNC     (HSYNC),
    .busy      (busy),
    .ctrl_done (ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void build_frame();
    q.push_back('{K_VS, SUD});
    for (int r = 0; r < int'(H); r++) begin
      q.push_back('{K_BLK, HSD});
      for (int c = 0; c < int'(W); c += 2) q.push_back('{K_DATA, r * int'(W) + c});
    end
    q.push_back('{K_DONE, 0});
  endfunction

  task automatic check_outputs(input logic ab);
    if (q.size() == 0) begin
      check("idle_busy", busy, 0);
      check("idle_valid", out_valid, 0);
      check("idle_vsync", VSYNC, 0);
      check("idle_hsync", HSYNC, 0);
      check("idle_done", ctrl_done, 0);
      check("idle_addr", pix_addr, 0);
      check("idle_row", row, 0);
      check("idle_col", col, 0);
    end else begin
      check("busy", busy, 1);
      case (q[0].kind)
        K_VS: begin
          check("vs_vsync", VSYNC, 1);
          check("vs_valid", out_valid, 0);
          check("vs_done", ctrl_done, 0);
        end
        K_BLK: begin
          check("blk_vsync", VSYNC, 0);
          check("blk_hsync", HSYNC, 0);
          check("blk_valid", out_valid, 0);
        end
        K_DATA: begin
          check("data_valid", out_valid, 1);
          check("data_hsync", HSYNC, 1);
          check("data_vsync", VSYNC, 0);
          check("data_addr", pix_addr, q[0].n);
          check("data_row", row, q[0].n / int'(W));
          check("data_col", col, q[0].n % int'(W));
        end
        default: begin
          check("done_pulse", ctrl_done, ab ? 0 : 1);
          check("done_valid", out_valid, 0);
          check("done_vsync", VSYNC, 0);
        end
      endcase
    end
  endtask

  function automatic void model_step(input logic st, input logic ab, input logic rdy);
    if (ab) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (st) build_frame();
    end else begin
      case (q[0].kind)
        K_VS, K_BLK: begin
          q[0].n--;
          if (q[0].n == 0) void'(q.pop_front());
        end
        K_DATA: if (rdy) void'(q.pop_front());
        default: begin
          void'(q.pop_front());
          done_seen++;
`ifdef AUTO_RESTART_EN
          build_frame();
`endif
        end
      endcase
    end
  endfunction

  task automatic tick(input logic st, input logic ab, input logic rdy);
    @(negedge HCLK);
    start = st;
    abort = ab;
    out_ready = rdy;
    #1;
    check_outputs(ab);
    model_step(st, ab, rdy);
  endtask

  function automatic bit head_is_data(input int a);
    return (q.size() != 0) && (q[0].kind == K_DATA) && (q[0].n == a);
  endfunction

  // Run with out_ready=1 until the model has seen 'target' completions; in
  // auto-restart builds the frame train is then ended with an abort.
  task automatic run_to_done(input int unsigned target);
    int unsigned budget = 0;
    while (done_seen < target && budget < 200) begin
      tick(1'b0, 1'b0, 1'b1);
      budget++;
    end
    check("frame_timeout", (done_seen >= target) ? 1 : 0, 1);
`ifdef AUTO_RESTART_EN
    tick(1'b0, 1'b1, 1'b1);
`endif
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_until_addr(input int a);
    int unsigned budget = 0;
    while (!head_is_data(a) && budget < 200) begin
      tick(1'b0, 1'b0, 1'b1);
      budget++;
    end
    check("addr_timeout", head_is_data(a) ? 1 : 0, 1);
  endtask

  initial begin
    int unsigned target;

    // Reset state, then 10 idle cycles without start.
    #13;
    check("rst_busy", busy, 0);
    check("rst_vsync", VSYNC, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", pix_addr, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);

    // Plain frame with out_ready held high.
    tick(1'b1, 1'b0, 1'b1);
    target = done_seen + 1;
    run_to_done(target);
`ifdef AUTO_RESTART_EN
    target = done_seen + 1;
    tick(1'b1, 1'b0, 1'b1);
    run_to_done(target + 1);
`endif

    // Back-pressure at address 2.
    tick(1'b1, 1'b0, 1'b1);
    run_until_addr(2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    target = done_seen + 1;
    run_to_done(target);

    // Abort during address 4, then a fresh frame from address 0.
    tick(1'b1, 1'b0, 1'b1);
    run_until_addr(4);
    target = done_seen;
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("abort_no_done", done_seen, target);
    tick(1'b1, 1'b0, 1'b1);
    run_until_addr(0);
    target = done_seen + 1;
    run_to_done(target);

    // start during DATA is ignored; start with abort in IDLE stays IDLE.
    tick(1'b1, 1'b0, 1'b1);
    run_until_addr(2);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    target = done_seen + 1;
    run_to_done(target);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of VSYNC.
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge HCLK);
    start = 1'b0;
    abort = 1'b0;
    #2;
    check("pre_rst_vsync", VSYNC, 1);
    HRESETn = 1'b0;
    #1;
    check("async_rst_vsync", VSYNC, 0);
    check("async_rst_busy", busy, 0);
    q.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_frame_sequencer.md
IMAGE_FRAME_SEQUENCER -- requirements
Module: image_frame_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1680, meaning image width in pixels (even, >= 2).
REQ-002 The block SHALL have parameter HEIGHT, default 1050, meaning image height in lines (>= 1).
REQ-003 The block SHALL have parameter START_UP_DELAY, default 100, meaning VSYNC duration in cycles (>= 1).
REQ-004 The block SHALL have parameter HSYNC_DELAY, default 160, meaning inter-line blank duration in cycles (>= 1).
REQ-005 The block SHALL have port HCLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port HRESETn, input, 1 bit, reset; asynchronous, active-low.
REQ-007 The block SHALL have port start, input, 1 bit, a frame request sampled only in IDLE.
REQ-008 The block SHALL have port abort, input, 1 bit, a synchronous frame cancel.
REQ-009 The block SHALL have port out_ready, input, 1 bit, the downstream datapath ready.
REQ-010 The block SHALL have port out_valid, output, 1 bit, which marks the pixel-pair address as valid.
REQ-011 The block SHALL have port pix_addr, output, ADDR_W = $clog2(WIDTH*HEIGHT) bits, the index of the even pixel of the pair.
REQ-012 The block SHALL have ports row (11 bits) and col (11 bits), outputs, the current line and even column.
REQ-013 The block SHALL have port VSYNC, output, 1 bit, the frame-start pulse.
REQ-014 The block SHALL have port HSYNC, output, 1 bit, the line-active flag.
REQ-015 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-016 The block SHALL have port ctrl_done, output, 1 bit, a one-cycle frame-complete pulse.

Function
REQ-017 The block SHALL implement FSM states IDLE, VSYNC, HSYNC, DATA and DONE.
REQ-018 In IDLE with start=1 and abort=0, the FSM SHALL enter VSYNC on the next edge; start SHALL be ignored in every other state.
REQ-019 The FSM SHALL hold VSYNC for exactly START_UP_DELAY cycles with output VSYNC=1, then enter HSYNC.
REQ-020 The FSM SHALL hold HSYNC for exactly HSYNC_DELAY cycles with outputs HSYNC=0 and out_valid=0, then enter DATA.
REQ-021 In DATA, the block SHALL drive out_valid=1, HSYNC=1 and pix_addr=row*WIDTH+col.
REQ-022 A beat SHALL be transferred only when out_valid and out_ready are both 1; on each beat col SHALL advance by 2.
REQ-023 While out_ready=0 in DATA, pix_addr, row and col SHALL hold, out_valid SHALL stay 1, and the FSM SHALL stay in DATA.
REQ-024 On a beat with col==WIDTH-2, col SHALL wrap to 0; if row==HEIGHT-1 the FSM SHALL enter DONE, otherwise row SHALL increment and the FSM SHALL enter HSYNC.
REQ-025 DONE SHALL last one cycle with ctrl_done=1, then the FSM SHALL enter IDLE with row and col cleared.
REQ-026 abort=1 in any state SHALL send the FSM to IDLE on the next edge, clear row, col and the delay counter, and suppress ctrl_done; abort SHALL win over start in the same cycle.
REQ-027 The delay counter SHALL be 16 bits and SHALL restart from 0 on every VSYNC or HSYNC entry.
REQ-028 pix_addr SHALL be registered, giving zero added latency from row/col.

Reset
REQ-029 While HRESETn=0, the state SHALL be IDLE and all outputs (out_valid, pix_addr, row, col, VSYNC, HSYNC, busy, ctrl_done) and counters SHALL be 0, immediately and independent of HCLK.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for start.

Configuration
REQ-031 With macro AUTO_RESTART_EN defined, DONE SHALL go to VSYNC instead of IDLE, giving continuous frames until abort; busy SHALL stay 1.
REQ-032 Without AUTO_RESTART_EN, DONE SHALL go to IDLE as per REQ-025.

Structure
REQ-033 Package image_ctrl_pkg SHALL hold the state enum, the default delay constants and the row/col width constants.
REQ-034 The delay counting SHALL be one sub-module, sync_timer: load, count and expire flag, 16-bit.

Verification (WIDTH=4, HEIGHT=2, START_UP_DELAY=3, HSYNC_DELAY=2)
REQ-035 Reset held low, then released with no start: all outputs SHALL be 0 and the FSM SHALL stay IDLE for 10 cycles.
REQ-036 A start pulse with out_ready=1 SHALL produce: VSYNC=1 for 3 cycles; 2 blank cycles; addresses 0 and 2 with HSYNC=1; 2 blank cycles; addresses 4 and 6; ctrl_done=1 for one cycle; then IDLE.
REQ-037 out_ready=0 for 3 cycles while pix_addr=2 SHALL hold pix_addr at 2 with out_valid=1; address 4 SHALL appear only after a beat with out_ready=1 plus HSYNC_DELAY blank cycles.
REQ-038 abort during pix_addr=4 SHALL give IDLE next cycle with busy=0 and no ctrl_done; a following start SHALL restart at pix_addr=0.
REQ-039 start during DATA SHALL have no effect, and start with abort in IDLE SHALL keep IDLE; HRESETn driven low mid-VSYNC SHALL zero VSYNC asynchronously.
REQ-040 With AUTO_RESTART_EN, the cycle after ctrl_done SHALL show VSYNC=1, and the second frame SHALL repeat addresses 0, 2, 4, 6.
